// File: rtl/axis_write_2d.sv
// axis_write_2d: strided stream-to-AXI writer.
// A four-word descriptor (base address, beats per row, row stride in bytes,
// row count) arrives over the shared config bus after the block's ID word.
// Each row is split into AXI write bursts of at most BURST_MAX beats; the
// stream is passed straight through to the W channel (no data buffering).
// Optional build macro: AXIS_WRITE_4K_SPLIT_EN -- when defined, bursts are
// also clamped so that none crosses a 4 KiB boundary.
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where the sender's valid and the receiver's ready are both high; a sender
// holds its payload stable while valid is high and ready is low.
module axis_write_2d #(
    parameter int CFG_ID         = 1,
    parameter int CFG_ADDR       = 23,
    parameter int CFG_DATA       = 24,
    parameter int CFG_AWIDTH     = 5,
    parameter int CFG_DWIDTH     = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BURST_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_AWIDTH-1:0]     cfg_addr,
    input  logic [CFG_DWIDTH-1:0]     cfg_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      busy,
    output logic                      done
);

    localparam int BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_CONFIG = 5'b00010,
        S_PREP   = 5'b00100,
        S_ADDR   = 5'b01000,
        S_DATA   = 5'b10000
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_word;
    logic [AXI_ADDR_WIDTH-1:0] r_base;
    logic [CFG_DWIDTH-1:0]     r_len;
    logic [CFG_DWIDTH-1:0]     r_stride;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_ADDR_WIDTH-1:0] r_row_base;
    logic [CFG_DWIDTH-1:0]     r_beats_left;
    logic [CFG_DWIDTH-1:0]     r_rows_left;
    logic [CFG_DWIDTH-1:0]     r_burst;
    logic [CFG_DWIDTH-1:0]     r_beat;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_LEN_WIDTH-1:0]  r_awlen;
    logic                      r_awvalid;
    logic                      r_done;

    logic                      w_cfg_ready;
    logic [AXI_ADDR_WIDTH-1:0] w_cfg_base;
    logic [CFG_DWIDTH-1:0]     w_burst_cap;
    logic [CFG_DWIDTH-1:0]     w_burst;
    logic                      w_wlast;
    logic                      w_w_hs;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_step;
    logic [CFG_DWIDTH-1:0]     w_beats_rem;
    logic [CFG_DWIDTH-1:0]     w_rows_rem;
    logic [AXI_ADDR_WIDTH-1:0] w_next_row_base;

    // Config bus is only accepted while no transfer is in progress.
    assign w_cfg_ready = (r_state == S_IDLE) || (r_state == S_CONFIG);

    // Base address is forced beat-aligned.
    assign w_cfg_base = AXI_ADDR_WIDTH'(cfg_data) & ~(AXI_ADDR_WIDTH'(BYTES - 1));

    assign w_burst_cap = (r_beats_left < CFG_DWIDTH'(BURST_MAX)) ?
                         r_beats_left : CFG_DWIDTH'(BURST_MAX);

`ifdef AXIS_WRITE_4K_SPLIT_EN
    logic [CFG_DWIDTH-1:0] w_4k_room;
    // Beats left before the next 4 KiB boundary (address is beat-aligned).
    assign w_4k_room = CFG_DWIDTH'((13'h1000 - {1'b0, r_addr[11:0]}) >> BSHIFT);
    assign w_burst   = (w_4k_room < w_burst_cap) ? w_4k_room : w_burst_cap;
`else
    assign w_burst   = w_burst_cap;
`endif

    // wlast comes purely from the beat counter, never from the stream valid.
    assign w_wlast         = (r_state == S_DATA) && (r_beat == r_burst - CFG_DWIDTH'(1));
    assign w_w_hs          = (r_state == S_DATA) && valid && axi_wready;
    assign w_addr_step     = AXI_ADDR_WIDTH'(r_burst) << BSHIFT;
    assign w_beats_rem     = r_beats_left - r_burst;
    assign w_rows_rem      = r_rows_left - CFG_DWIDTH'(1);
    assign w_next_row_base = r_row_base + AXI_ADDR_WIDTH'(r_stride);

    assign cfg_ready   = w_cfg_ready;
    assign axi_awaddr  = r_awaddr;
    assign axi_awlen   = r_awlen;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = data;
    assign axi_wvalid  = (r_state == S_DATA) && valid;
    assign axi_wlast   = w_wlast;
    assign ready       = (r_state == S_DATA) && axi_wready;
    // busy covers the done cycle even though the FSM is already back in IDLE.
    assign busy        = (r_state == S_PREP) || (r_state == S_ADDR) ||
                         (r_state == S_DATA) || r_done;
    assign done        = r_done;

    // Descriptor capture, burst planning and W-channel beat tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_stride     <= '0;
            r_addr       <= '0;
            r_row_base   <= '0;
            r_beats_left <= '0;
            r_rows_left  <= '0;
            r_burst      <= '0;
            r_beat       <= '0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awvalid    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_ADDR) &&
                        cfg_data == CFG_DWIDTH'(CFG_ID)) begin
                        r_word  <= '0;
                        r_state <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_DATA)) begin
                        r_word <= r_word + 2'd1;
                        case (r_word)
                            2'd0: r_base   <= w_cfg_base;
                            2'd1: r_len    <= cfg_data;
                            2'd2: r_stride <= cfg_data;
                            default: begin
                                r_rows_left  <= cfg_data;
                                r_addr       <= r_base;
                                r_row_base   <= r_base;
                                r_beats_left <= r_len;
                                r_state      <= S_PREP;
                            end
                        endcase
                    end
                end
                S_PREP: begin
                    if (r_len == '0 || r_rows_left == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_burst   <= w_burst;
                        r_awaddr  <= r_addr;
                        r_awlen   <= AXI_LEN_WIDTH'(w_burst - CFG_DWIDTH'(1));
                        r_awvalid <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        if (w_wlast) begin
                            r_beat <= '0;
                            if (w_beats_rem == '0) begin
                                r_rows_left  <= w_rows_rem;
                                r_row_base   <= w_next_row_base;
                                r_addr       <= w_next_row_base;
                                r_beats_left <= r_len;
                                if (w_rows_rem == '0) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_state <= S_PREP;
                                end
                            end else begin
                                r_addr       <= r_addr + w_addr_step;
                                r_beats_left <= w_beats_rem;
                                r_state      <= S_PREP;
                            end
                        end else begin
                            r_beat <= r_beat + CFG_DWIDTH'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_write_2d.md
# axis_write_2d

Stride-capable successor to the single-region stream-to-AXI writer. Takes a four-word descriptor over the shared config bus (base address, row length, row stride, row count). Drains the system stream into AXI write bursts, splitting each row into bursts of at most `BURST_MAX` beats. Sits between the config interconnect and one AXI HP write port. Handles one outstanding burst at a time, with no internal data buffer.

## Interface
- `CFG_ID`, 1: value on `cfg_data` that selects this block.
- `CFG_ADDR`, 23: `cfg_addr` value carrying the ID word.
- `CFG_DATA`, 24: `cfg_addr` value carrying descriptor words.
- `CFG_AWIDTH`, 5: config address width.
- `CFG_DWIDTH`, 32: config data width; also the width of the length, stride and count registers.
- `AXI_LEN_WIDTH`, 8: width of `axi_awlen`.
- `AXI_ADDR_WIDTH`, 32: byte-address width.
- `AXI_DATA_WIDTH`, 32: beat width. `BYTES = AXI_DATA_WIDTH/8` (power of two).
- `BURST_MAX`, 16: maximum beats per burst. Must be ≤ 2^`AXI_LEN_WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_addr` in `CFG_AWIDTH`; `cfg_data` in `CFG_DWIDTH`; `cfg_valid` in 1; `cfg_ready` out 1: config bus.
- `axi_awaddr` out `AXI_ADDR_WIDTH`; `axi_awlen` out `AXI_LEN_WIDTH`; `axi_awvalid` out 1; `axi_awready` in 1: write-address channel.
- `axi_wdata` out `AXI_DATA_WIDTH`; `axi_wlast` out 1; `axi_wvalid` out 1; `axi_wready` in 1: write-data channel.
- `data` in `AXI_DATA_WIDTH`; `valid` in 1; `ready` out 1: system stream.
- `busy` out 1: high from descriptor acceptance until completion.
- `done` out 1: one-cycle pulse when a descriptor completes.

## Operation
- States (one-hot): IDLE, CONFIG, PREP, ADDR, DATA.
- IDLE → CONFIG when `cfg_valid` and `cfg_addr==CFG_ADDR` and `cfg_data==CFG_ID`. An ID mismatch is ignored.
- CONFIG: each `cfg_valid` with `cfg_addr==CFG_DATA` shifts in one word, in the order address, length (beats per row), stride (bytes), count (rows). Other addresses are ignored. The 4th word moves the block to PREP.
- PREP computes `burst = min(beats_left, BURST_MAX)`, reduced by the 4K limit when enabled (see Configuration), and registers `axi_awaddr` and `axi_awlen = burst-1`.
- PREP → ADDR. There is one exception: if length==0 or count==0, PREP → IDLE with `done` and no AXI traffic.
- ADDR: `axi_awvalid` is high and holds until `axi_awready`, then → DATA.
- DATA is a combinational pass-through:
  - `axi_wdata = data`
  - `axi_wvalid = valid`
  - `ready = axi_wready`
  - A beat counter drives `axi_wlast` on beat `burst`.
  - Outside DATA, `ready` and `axi_wvalid` are 0.
- After the wlast handshake:
  - `addr += burst*BYTES` and `beats_left -= burst`.
  - If `beats_left==0`: `rows_left -= 1`, `row_base += stride`, `addr = row_base` (new value), and `beats_left = length`.
  - If `rows_left==0` → IDLE with `done`; otherwise → PREP.
- Address arithmetic wraps modulo 2^`AXI_ADDR_WIDTH`. The low log2(`BYTES`) bits of the base address are forced to 0. Stride is not masked.
- `cfg_ready` = IDLE or CONFIG. While busy, config writes are stalled, never dropped.
- Reset in any state: → IDLE immediately. Any in-flight burst is abandoned, since reset is system-wide.

## Timing
- Reset values:
  - `axi_awvalid`, `axi_wvalid`, `axi_wlast`, `ready`, `busy`, `done` = 0.
  - `axi_awaddr`, `axi_awlen` = 0.
  - `cfg_ready` = 1.
- Last descriptor word accepted at cycle T: PREP at T+1; `axi_awvalid` = 1 at T+2.
- After the wlast handshake at cycle W: next `axi_awvalid` at W+2, or `done` = 1 at W+1.
- `busy` is high from T+1 up to and including the `done` cycle.
- `axi_awaddr` and `axi_awlen` are stable while `axi_awvalid` is high and not acknowledged.
- `axi_wlast` depends only on the beat counter, never on `valid`.

## Configuration
- `AXIS_WRITE_4K_SPLIT_EN` defined: PREP additionally clamps `burst` to `(4096 - addr[11:0]) / BYTES`, so no burst crosses a 4 KiB boundary.
- `AXIS_WRITE_4K_SPLIT_EN` undefined: the clamp is absent, and 4 KiB alignment is the software's responsibility.

## Test plan
Defaults apply unless stated (`BYTES`=4, `BURST_MAX`=16).
1. ID, then words 0x1000/20/0x100/2, stream 40 beats → AW 0x1000 len15, 0x1040 len3, 0x1100 len15, 0x1140 len3. `wlast` on beats 16, 20, 36, 40. One `done` pulse.
2. Descriptor 0x0FF8/8/0/1 → with `AXIS_WRITE_4K_SPLIT_EN`: AW 0x0FF8 len1, then 0x1000 len5. Without: a single AW 0x0FF8 len7.
3. Count=0 (or length=0) → no `axi_awvalid`. `done` at T+2. `cfg_ready` high again at T+2.
4. `axi_awready` held low for 5 cycles and `axi_wready` toggled every cycle on test 1 → AW fields stable, `ready` mirrors `axi_wready`, exactly 40 beats transferred, no duplicates.
5. ID word 2 (≠`CFG_ID`) → stays IDLE. A second descriptor issued while busy → `cfg_ready` = 0 until `done`, then it is accepted.
6. `rst` pulsed during DATA of burst 2 → all outputs at reset values the next cycle. A fresh descriptor then runs normally.
